cmp_stream_unit: RTL and testbench

Parametrised, handshaked successor to the ALU compare unit. Compares two WIDTH-bit operands, signed or unsigned, and supports the legacy EQ/GT/LT result codes, MAX/MIN selection, and a running MAX/MIN accumulator over a stream of samples. It sits in the ALU datapath beside the arithmetic and logic units. It has valid/ready flow control on input and output, so the UART command FSM can stall it.

---
 rtl/cmp_pkg.sv | 26 ++
 rtl/cmp_core.sv | 28 ++
 rtl/cmp_stream_unit.sv | 124 ++++++++++++
 tb/tb_cmp_stream_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare/stream unit: opcodes, legacy result codes
// and the bit positions of the {eq, gt, lt} flag vector.
package cmp_pkg;

  localparam logic [2:0] CMP_NOP    = 3'b000;
  localparam logic [2:0] CMP_EQ     = 3'b001;
  localparam logic [2:0] CMP_GT     = 3'b010;
  localparam logic [2:0] CMP_LT     = 3'b011;
  localparam logic [2:0] CMP_MAX    = 3'b100;
  localparam logic [2:0] CMP_MIN    = 3'b101;
  localparam logic [2:0] CMP_RUNMAX = 3'b110;
  localparam logic [2:0] CMP_RUNMIN = 3'b111;

  localparam int CMP_EQ_CODE = 1;
  localparam int CMP_GT_CODE = 2;
  localparam int CMP_LT_CODE = 3;

  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  function automatic logic is_run_op(input logic [2:0] func);
    return func[2] & func[1];
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator; signed mode biases the sign bit so a
// single unsigned compare serves both encodings.
module cmp_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_en,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [WIDTH-1:0] x_biased;
  logic [WIDTH-1:0] y_biased;

  always_comb begin
    x_biased = x;
    y_biased = y;
    x_biased[WIDTH-1] = x[WIDTH-1] ^ signed_en;
    y_biased[WIDTH-1] = y[WIDTH-1] ^ signed_en;
  end

  assign eq = (x == y);
  assign gt = (x_biased > y_biased);
  assign lt = (x_biased < y_biased);

endmodule

// File: rtl/cmp_stream_unit.sv
// Handshaked compare unit: legacy EQ/GT/LT codes, MAX/MIN select and a running
// MAX/MIN accumulator with a saturating sample counter. One-cycle latency.
module cmp_stream_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           func,
  input  logic                 signed_en,
  input  logic                 run_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     cmp_out,
  output logic [2:0]           cmp_flags,
  output logic [CNT_WIDTH-1:0] run_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     cmp_out_reg, cmp_out_next;
  logic [2:0]           flags_reg, flags_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;
  logic                 acc_full_reg, acc_full_next;
  logic [CNT_WIDTH-1:0] run_cnt_reg, run_cnt_next;

  logic accept;
  logic ab_eq, ab_gt, ab_lt;
  logic aa_eq, aa_gt, aa_lt;
  logic acc_full_eff;
  logic [CNT_WIDTH-1:0] cnt_base;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  cmp_core #(.WIDTH(WIDTH)) u_core_ab (
    .x(a), .y(b), .signed_en(signed_en),
    .eq(ab_eq), .gt(ab_gt), .lt(ab_lt)
  );

  cmp_core #(.WIDTH(WIDTH)) u_core_acc (
    .x(a), .y(acc_reg), .signed_en(signed_en),
    .eq(aa_eq), .gt(aa_gt), .lt(aa_lt)
  );

  // A same-cycle clear is applied before any RUN op, so the op sees an empty acc.
  assign acc_full_eff = acc_full_reg && !run_clr;
  assign cnt_base     = run_clr ? '0 : run_cnt_reg;

  always_comb begin
    cmp_out_next           = '0;
    flags_next             = '0;
    flags_next[FLAG_EQ]    = ab_eq;
    flags_next[FLAG_GT]    = ab_gt;
    flags_next[FLAG_LT]    = ab_lt;
    acc_next               = run_clr ? '0 : acc_reg;
    acc_full_next          = acc_full_eff;
    run_cnt_next           = cnt_base;

    if (accept) begin
      case (func)
        CMP_NOP: cmp_out_next = '0;
        CMP_EQ:  cmp_out_next = ab_eq ? WIDTH'(CMP_EQ_CODE) : '0;
        CMP_GT:  cmp_out_next = ab_gt ? WIDTH'(CMP_GT_CODE) : '0;
        CMP_LT:  cmp_out_next = ab_lt ? WIDTH'(CMP_LT_CODE) : '0;
        CMP_MAX: cmp_out_next = ab_lt ? b : a;
        CMP_MIN: cmp_out_next = ab_gt ? b : a;
        default: begin
          if (!acc_full_eff) begin
            acc_next   = a;
            flags_next = '0;
          end else begin
            flags_next[FLAG_EQ] = aa_eq;
            flags_next[FLAG_GT] = aa_gt;
            flags_next[FLAG_LT] = aa_lt;
            if (func == CMP_RUNMAX) acc_next = aa_gt ? a : acc_reg;
            else                    acc_next = aa_lt ? a : acc_reg;
          end
          cmp_out_next  = acc_next;
          acc_full_next = 1'b1;
          run_cnt_next  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
        end
      endcase
      if (!is_run_op(func)) begin
        acc_next      = run_clr ? '0 : acc_reg;
        acc_full_next = acc_full_eff;
        run_cnt_next  = cnt_base;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      cmp_out_reg   <= '0;
      flags_reg     <= '0;
      acc_reg       <= '0;
      acc_full_reg  <= 1'b0;
      run_cnt_reg   <= '0;
    end else begin
      out_valid_reg <= accept || (out_valid_reg && !out_ready);
      if (accept) begin
        cmp_out_reg <= cmp_out_next;
        flags_reg   <= flags_next;
      end
      acc_reg      <= acc_next;
      acc_full_reg <= acc_full_next;
      run_cnt_reg  <= run_cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign cmp_out   = cmp_out_reg;
  assign cmp_flags = flags_reg;
  assign run_cnt   = run_cnt_reg;

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Directed bench for cmp_stream_unit; a second instance with CNT_WIDTH=2
// shares the stimulus to exercise counter saturation.
module tb_cmp_stream_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_ready2;
  logic [15:0] a, b;
  logic [2:0]  func;
  logic        signed_en, run_clr;
  logic        out_valid, out_valid2, out_ready;
  logic [15:0] cmp_out, cmp_out2;
  logic [2:0]  cmp_flags, cmp_flags2;
  logic [7:0]  run_cnt;
  logic [1:0]  run_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_stream_unit #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .signed_en(signed_en), .run_clr(run_clr),
    .out_valid(out_valid), .out_ready(out_ready), .cmp_out(cmp_out),
    .cmp_flags(cmp_flags), .run_cnt(run_cnt)
  );

  cmp_stream_unit #(.WIDTH(16), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .func(func), .signed_en(signed_en), .run_clr(run_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .cmp_out(cmp_out2),
    .cmp_flags(cmp_flags2), .run_cnt(run_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted op per call; outputs are sampled 1 ns after the edge.
  task automatic op(input string tag, input logic [2:0] f, input logic [15:0] va,
                    input logic [15:0] vb, input logic sgn, input logic clr,
                    input logic [15:0] exp_out, input logic [2:0] exp_flags);
    func = f; a = va; b = vb; signed_en = sgn; run_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; run_clr = 1'b0;
    $display("op %s func=%0d a=%0h b=%0h -> out=%0h flags=%b cnt=%0d", tag, f, va, vb,
             cmp_out, cmp_flags, run_cnt);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".out"}, cmp_out, exp_out);
    check({tag, ".flags"}, cmp_flags, exp_flags);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; func = 3'd0;
    signed_en = 1'b0; run_clr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.cmp_out", cmp_out, 0);
    check("rst.flags", cmp_flags, 0);
    check("rst.run_cnt", run_cnt, 0);
    check("rst.in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // legacy codes, back to back
    op("eq", 3'b001, 16'd5, 16'd5, 1'b0, 1'b0, 16'd1, 3'b100);
    op("gt", 3'b010, 16'd7, 16'd3, 1'b0, 1'b0, 16'd2, 3'b010);
    op("lt", 3'b011, 16'd3, 16'd7, 1'b0, 1'b0, 16'd3, 3'b001);
    op("eq0", 3'b001, 16'd3, 16'd7, 1'b0, 1'b0, 16'd0, 3'b001);
    op("nop", 3'b000, 16'd9, 16'd9, 1'b0, 1'b0, 16'd0, 3'b100);

    // signedness on MAX/MIN
    op("max_u", 3'b100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 3'b010);
    op("max_s", 3'b100, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 3'b001);
    op("min_u", 3'b101, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0001, 3'b010);
    op("min_s", 3'b101, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 3'b001);
    check("nonrun.run_cnt", run_cnt, 0);

    // running max stream after a standalone clear
    run_clr = 1'b1; @(posedge clk); #1; run_clr = 1'b0;
    op("rmax4", 3'b110, 16'd4, 16'd0, 1'b0, 1'b0, 16'd4, 3'b000);
    check("rmax4.cnt", run_cnt, 1);
    op("rmax9", 3'b110, 16'd9, 16'd0, 1'b0, 1'b0, 16'd9, 3'b010);
    check("rmax9.cnt", run_cnt, 2);
    op("rmax2", 3'b110, 16'd2, 16'd0, 1'b0, 1'b0, 16'd9, 3'b001);
    check("rmax2.cnt", run_cnt, 3);
    op("rmax9b", 3'b110, 16'd9, 16'd0, 1'b0, 1'b0, 16'd9, 3'b100);
    check("rmax9b.cnt", run_cnt, 4);
    check("sat.cnt2_a", run_cnt2, 3);
    op("nop_run", 3'b000, 16'd1, 16'd2, 1'b0, 1'b0, 16'd0, 3'b001);
    check("nop_run.cnt", run_cnt, 4);
    op("rmin_clr", 3'b111, 16'd6, 16'd0, 1'b0, 1'b1, 16'd6, 3'b000);
    check("rmin_clr.cnt", run_cnt, 1);
    check("rmin_clr.cnt2", run_cnt2, 1);

    // five RUN ops since the clear: narrow counter saturates
    op("rmax1", 3'b110, 16'd1, 16'd0, 1'b0, 1'b0, 16'd6, 3'b001);
    op("rmin2", 3'b111, 16'd2, 16'd0, 1'b0, 1'b0, 16'd2, 3'b001);
    op("rmaxF", 3'b110, 16'hFFF0, 16'd0, 1'b1, 1'b0, 16'd2, 3'b001);
    op("rmax8", 3'b110, 16'd8, 16'd0, 1'b0, 1'b0, 16'd8, 3'b010);
    check("sat.cnt", run_cnt, 5);
    check("sat.cnt2", run_cnt2, 3);

    // back-pressure: GT result held, EQ queued
    op("bp_gt", 3'b010, 16'd7, 16'd3, 1'b0, 1'b0, 16'd2, 3'b010);
    out_ready = 1'b0;
    func = 3'b001; a = 16'd1; b = 16'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.out", cmp_out, 2);
      check("bp.flags", cmp_flags, 3'b010);
      check("bp.in_ready", in_ready, 0);
      check("bp.valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("op bp_eq released -> out=%0h flags=%b", cmp_out, cmp_flags);
    check("bp_eq.out", cmp_out, 1);
    check("bp_eq.flags", cmp_flags, 3'b100);
    check("bp_eq.valid", out_valid, 1);
    @(posedge clk); #1;
    check("drain.valid", out_valid, 0);

    // async reset with a pending result and a full accumulator
    op("pre_rst", 3'b110, 16'd20, 16'd0, 1'b0, 1'b0, 16'd20, 3'b010);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst.valid", out_valid, 0);
    check("arst.out", cmp_out, 0);
    check("arst.flags", cmp_flags, 0);
    check("arst.cnt", run_cnt, 0);
    check("arst.in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    op("post_rst", 3'b110, 16'd2, 16'd0, 1'b0, 1'b0, 16'd2, 3'b000);
    check("post_rst.cnt", run_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
